// File: rtl/nibble_serial_adder.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder
//
// Adds two W-bit operands (W = 4*NIBBLES) plus a carry-in by pushing one
// 4-bit slice per clock through a single 4-bit carry-look-ahead adder.
// Operands are captured on a valid/ready handshake, the result is presented
// with a valid/ready handshake and held until the consumer takes it.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst       : asynchronous active-high reset
//   in_valid  : operand request valid
//   in_ready  : block is idle and can accept operands
//   a, b      : W-bit operands
//   cin       : carry-in to the least significant nibble
//   sum       : W+1-bit result, sum[W] is the final carry-out
//   out_valid : sum holds a finished result
//   out_ready : consumer accepts sum
//   busy      : high while nibbles are being added
//
// Also contains carry_look_ahead_adder, the 4-bit adder slice.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// carry_look_ahead_adder
//
// Purely combinational 4-bit adder with all carries computed in parallel
// from generate/propagate terms.
//
// Ports
//   A, B     : 4-bit addends
//   cin      : carry-in
//   finalsum : {carry-out, 4-bit sum}
// ---------------------------------------------------------------------------
module carry_look_ahead_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       cin,
    output logic [4:0] finalsum
);

    logic [3:0] gen;
    logic [3:0] prop;
    logic [4:0] carry;

    // Each carry is expanded directly from generate/propagate so no carry
    // depends on the previous carry output.
    always_comb begin
        gen      = A & B;
        prop     = A ^ B;
        carry[0] = cin;
        carry[1] = gen[0] | (prop[0] & cin);
        carry[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin);
        carry[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
                 | (prop[2] & prop[1] & prop[0] & cin);
        carry[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                 | (prop[3] & prop[2] & prop[1] & gen[0])
                 | (prop[3] & prop[2] & prop[1] & prop[0] & cin);
        finalsum = {carry[4], prop ^ carry[3:0]};
    end

endmodule

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
    output logic [4*NIBBLES:0]   sum,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST_NIBBLE = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    opA_q, opA_d;
    logic [W-1:0]    opB_q, opB_d;
    logic            carry_q, carry_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W:0]      sum_q, sum_d;
    logic [4:0]      claSum;

    // The only adder in the block; it always sees the low nibble of the
    // shifting operand registers and the carry left by the previous slice.
    carry_look_ahead_adder u_cla (
        .A        (opA_q[3:0]),
        .B        (opB_q[3:0]),
        .cin      (carry_q),
        .finalsum (claSum)
    );

    // Next-state logic. Operands are copied into private shift registers on
    // accept, so the inputs are free to change for the rest of the operation.
    // sum is only touched on accept (cleared) and during ADD; in DONE and
    // IDLE it keeps the last result.
    always_comb begin
        state_d = state_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opA_d   = a;
                    opB_d   = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = ADD;
                end
            end

            ADD: begin
                sum_d[4*cnt_q +: 4] = claSum[3:0];
                carry_d             = claSum[4];
                opA_d               = opA_q >> 4;
                opB_d               = opB_q >> 4;
                cnt_d               = cnt_q + 1'b1;
                // The carry out of the top slice becomes the extra result bit.
                if (cnt_q == LAST_NIBBLE) begin
                    sum_d[W] = claSum[4];
                    state_d  = DONE;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset clears everything without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            opA_q   <= '0;
            opB_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
        end
    end

    // Handshake and status outputs are decoded straight from the state so
    // they follow an asynchronous reset immediately.
    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == ADD);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;

endmodule
